// File: rtl/iter_shift_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : iter_shift_unit_if
//  Purpose  : Start/busy/done handshake bundle between the control FSM
//             (master) and the iterative shifter (slave).
//  Signals  : start  - request, master -> slave
//             a      - operand, master -> slave
//             shamt  - shift amount, master -> slave
//             dir    - 0 = left, 1 = right, master -> slave
//             arith  - sign fill on right shifts, master -> slave
//             busy   - shift in progress, slave -> master
//             done   - one-cycle completion pulse, slave -> master
//             result - shifted value, slave -> master
//  Revision : 1.0  initial release
// ============================================================================
interface iter_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
    logic               arith;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, a, shamt, dir, arith,
        input  busy, done, result
    );

    modport slave (
        input  start, a, shamt, dir, arith,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : iter_shift_unit
//  Purpose  : Multi-cycle SLL/SRL/SRA. One power-of-two stage is applied per
//             clock (16, 8, 4, 2, 1), giving a fixed SHAMT_W-cycle latency
//             in exchange for a single small mux per bit instead of a
//             full barrel shifter.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - iter_shift_unit_if.slave (start/a/shamt/dir/arith in,
//                    busy/done/result out)
//  Revision : 1.0  initial release
// ============================================================================
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    iter_shift_unit_if.slave bus
);

    localparam int c_K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [c_K_W-1:0] c_K_FIRST = c_K_W'(SHAMT_W - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_accept;

    logic [WIDTH-1:0]   r_acc;
    logic [c_K_W-1:0]   r_k;
    logic [SHAMT_W-1:0] r_shamt;
    logic               r_dir;
    logic               r_arith;
    logic               r_sign;

    logic               w_fill;
    logic [WIDTH-1:0]   w_stage_l [SHAMT_W];
    logic [WIDTH-1:0]   w_stage_r [SHAMT_W];
    logic [WIDTH-1:0]   w_acc_shifted;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A start is honoured in IDLE and DONE only, so a
    // request arriving in the done cycle chains straight into SHIFT.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (r_k == '0) begin
                    w_state_next = c_S_DONE;
                end
            end
            c_S_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_S_SHIFT;
                end else begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fixed-distance stage candidates. Right-shift fill comes from the
    // operand's original MSB captured at start, gated by the arith flag.
    // ------------------------------------------------------------------
    assign w_fill = r_arith & r_sign;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int c_SH = 1 << i;
        assign w_stage_l[i] = {r_acc[WIDTH-1-c_SH:0], {c_SH{1'b0}}};
        assign w_stage_r[i] = {{c_SH{w_fill}}, r_acc[WIDTH-1:c_SH]};
    end

    assign w_acc_shifted = r_dir ? w_stage_r[r_k] : w_stage_l[r_k];

    // ------------------------------------------------------------------
    // Datapath: operand capture on accept, one conditional stage per
    // SHIFT cycle. r_acc is the architectural result, so it is left
    // untouched outside SHIFT and therefore stays stable after done.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_k     <= c_K_FIRST;
            r_shamt <= '0;
            r_dir   <= 1'b0;
            r_arith <= 1'b0;
            r_sign  <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= bus.a;
            r_k     <= c_K_FIRST;
            r_shamt <= bus.shamt;
            r_dir   <= bus.dir;
            r_arith <= bus.arith;
            r_sign  <= bus.a[WIDTH-1];
        end else if (r_state == c_S_SHIFT) begin
            if (r_shamt[r_k]) begin
                r_acc <= w_acc_shifted;
            end
            // Hold at zero on the last stage; the next accept reloads it.
            if (r_k != '0) begin
                r_k <= r_k - c_K_W'(1);
            end
        end
    end

    // Status decodes straight from the state register so that an
    // asynchronous reset clears them without waiting for a clock.
    assign bus.busy   = (r_state == c_S_SHIFT);
    assign bus.done   = (r_state == c_S_DONE);
    assign bus.result = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_shift_unit
//  Purpose  : Directed and random self-checking bench for iter_shift_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iter_shift_unit;

    localparam int c_WIDTH   = 32;
    localparam int c_SHAMT_W = 5;
    localparam int c_LAT     = 5;
    localparam int c_TIMEOUT = 20;

    logic clk;
    logic rst;
    int   check_cnt;
    int   fail_cnt;

    iter_shift_unit_if #(.WIDTH(c_WIDTH), .SHAMT_W(c_SHAMT_W)) bus ();

    iter_shift_unit #(
        .WIDTH   (c_WIDTH),
        .SHAMT_W (c_SHAMT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns number of edges until done is seen.
    task automatic wait_done(output int lat);
        lat = c_TIMEOUT + 1;
        for (int c = 1; c <= c_TIMEOUT; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] ra, input logic [4:0] rs,
                                              input logic rd, input logic rar);
        if (!rd)      return ra << rs;
        else if (rar) return $unsigned($signed(ra) >>> rs);
        else          return ra >> rs;
    endfunction

    // Called #1 after an edge. Issues one op, checks latency, result and
    // done width, then returns #1 after the edge following the done cycle.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [4:0] ts,
                          input logic td, input logic tar, input logic [31:0] exp);
        int lat;
        bus.a     = ta;
        bus.shamt = ts;
        bus.dir   = td;
        bus.arith = tar;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.shamt = 5'($urandom);
        bus.dir   = 1'($urandom);
        bus.arith = 1'($urandom);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(c_LAT));
        chk({tag, "_res"}, bus.result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_donew"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        int          lat;
        logic [31:0] ra;
        logic [4:0]  rs;
        logic        rd;
        logic        rar;

        check_cnt = 0;
        fail_cnt  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.shamt = '0;
        bus.dir   = 1'b0;
        bus.arith = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res",  bus.result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1 / T2 / T3 directed
        run_op("t1_sra4",     32'h8000_0000, 5'd4,  1'b1, 1'b1, 32'hF800_0000);
        run_op("t1_srl4",     32'h8000_0000, 5'd4,  1'b1, 1'b0, 32'h0800_0000);
        run_op("t2_sll31",    32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
        run_op("t2_sll8",     32'h1234_5678, 5'd8,  1'b0, 1'b0, 32'h3456_7800);
        run_op("t3_srl31",    32'hFFFF_FFF0, 5'd31, 1'b1, 1'b0, 32'h0000_0001);
        run_op("t3_sra31",    32'hFFFF_FFF0, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);
        run_op("t3_sh0",      32'hFFFF_FFF0, 5'd0,  1'b1, 1'b1, 32'hFFFF_FFF0);
        run_op("sll_arith",   32'h8000_0001, 5'd1,  0,    1'b1, 32'h0000_0002);
        run_op("sra_pos",     32'h7000_0000, 5'd3,  1'b1, 1'b1, 32'h0E00_0000);

        // T4a: start held high with a new operand throughout SHIFT
        bus.a = 32'h0000_00FF; bus.shamt = 5'd4; bus.dir = 1'b0; bus.arith = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 32'hDEAD_BEEF; bus.shamt = 5'd1; bus.dir = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t4_busy_hold", 32'(bus.busy), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk("t4_ign_lat", 32'(lat), 32'd1);
        chk("t4_ign_res", bus.result, 32'h0000_0FF0);

        // T4b: start in the done cycle chains a second op
        @(posedge clk);
        #1;
        bus.a = 32'h0000_0003; bus.shamt = 5'd2; bus.dir = 1'b0; bus.arith = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk("t4_op1_res", bus.result, 32'h0000_000C);
        bus.a = 32'hF000_0000; bus.shamt = 5'd8; bus.dir = 1'b1; bus.arith = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("t4_b2b_busy", 32'(bus.busy), 32'd1);
        chk("t4_b2b_done", 32'(bus.done), 32'd0);
        wait_done(lat);
        chk("t4_b2b_lat", 32'(lat), 32'(c_LAT));
        chk("t4_b2b_res", bus.result, 32'hFFF0_0000);
        @(posedge clk);
        #1;

        // T5: asynchronous reset mid-SHIFT
        bus.a = 32'hFFFF_FFFF; bus.shamt = 5'd1; bus.dir = 1'b0; bus.arith = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("t5_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_res",  bus.result, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) lat++;
        end
        chk("t5_no_done", 32'(lat), 32'd0);
        run_op("t5_after", 32'h1234_5678, 5'd16, 1'b1, 1'b0, 32'h0000_1234);

        // T6: random against reference operators
        for (int n = 0; n < 1000; n++) begin
            ra  = $urandom;
            rs  = 5'($urandom);
            rd  = 1'($urandom);
            rar = 1'($urandom);
            run_op("t6_rand", ra, rs, rd, rar, ref_shift(ra, rs, rd, rar));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
